sprite_anim_ctrl: RTL and testbench



---
 rtl/sprite_anim_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl
//   Steps the overworld player's two-frame walk animation on video-frame
//   ticks, selects the matching per-direction sprite ROM, and turns the raster
//   position into a ROM pixel index. It returns an opaque/transparent RGB565
//   pixel to the mixer through a two-stage pipeline.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse at start of vertical blank
//   dir                   facing: 0 down, 1 up, 2 left, 3 right
//   moving                walking request from movement logic
//   sprite_x, sprite_y    sprite top-left position (committed on frame_tick)
//   hcount, vcount        current raster position
//   rom_width, rom_height size of the selected ROM image
//   rom_color             colour from the ROM bank for rom_pixel
//   rom_sel               ROM select {dir, anim_frame}, committed on frame_tick
//   rom_pixel             pixel index into the selected ROM (stage 1)
//   anim_frame            current walk frame
//   pix_color, pix_opaque sprite pixel for the mixer (stage 2)
module sprite_anim_ctrl #(
  parameter int          FRAMES_PER_STEP = 8,
  parameter logic [15:0] TRANSPARENT     = 16'hFFFF,
  parameter int          COORD_W         = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [1:0]         dir,
  input  logic               moving,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [5:0]         rom_width,
  input  logic [5:0]         rom_height,
  input  logic [15:0]        rom_color,
  output logic [2:0]         rom_sel,
  output logic [16:0]        rom_pixel,
  output logic               anim_frame,
  output logic [15:0]        pix_color,
  output logic               pix_opaque
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  // One extra bit so position + size never wraps at the right/bottom edge.
  localparam int EW = COORD_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_q, frame_d;
  logic [2:0]         rom_sel_q;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [16:0]        rom_pixel_q, rom_pixel_d;
  logic               inbox_q, inbox_d;
  logic [15:0]        pix_color_q;
  logic               pix_opaque_q;

  // ---------------------------------------------------------------------------
  // Walk animation next state. Dropping 'moving' wins over a coincident tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (moving) begin
          state_d = WALK_A;
          cnt_d   = '0;
        end
      end
      WALK_A, WALK_B: begin
        if (!moving) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = (state_q == WALK_A) ? WALK_B : WALK_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    frame_d = (state_d == WALK_B);
  end

  // ---------------------------------------------------------------------------
  // Stage 1: box test and pixel index against the committed position.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] hx, vy, px, py, px_end, py_end, dx, dy;
  logic          inbox_c;
  logic [16:0]   idx_c;

  always_comb begin
    hx      = {1'b0, hcount};
    vy      = {1'b0, vcount};
    px      = {1'b0, pos_x_q};
    py      = {1'b0, pos_y_q};
    px_end  = px + EW'(rom_width);
    py_end  = py + EW'(rom_height);
    dx      = hx - px;
    dy      = vy - py;
    // A zero width or height makes the upper bound equal the lower one,
    // so such a sprite is never in the box.
    inbox_c = (hx >= px) && (hx < px_end) && (vy >= py) && (vy < py_end);
    idx_c   = 17'(dy) * 17'(rom_width) + 17'(dx);
    rom_pixel_d = inbox_c ? idx_c : 17'd0;
    inbox_d     = inbox_c;
  end

  // ---------------------------------------------------------------------------
  // All state. Selection and position only move on frame_tick so the sprite
  // never tears mid-frame; the pixel already in stage 1 finishes unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
      rom_sel_q    <= 3'd0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      rom_pixel_q  <= 17'd0;
      inbox_q      <= 1'b0;
      pix_color_q  <= 16'd0;
      pix_opaque_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      if (frame_tick) begin
        rom_sel_q <= {dir, frame_d};
        pos_x_q   <= sprite_x;
        pos_y_q   <= sprite_y;
      end
      rom_pixel_q <= rom_pixel_d;
      inbox_q     <= inbox_d;
      // Stage 2: rom_color belongs to rom_pixel_q, aligned with inbox_q.
      if (inbox_q && (rom_color != TRANSPARENT)) begin
        pix_opaque_q <= 1'b1;
        pix_color_q  <= rom_color;
      end else begin
        pix_opaque_q <= 1'b0;
        pix_color_q  <= 16'd0;
      end
    end
  end

  assign rom_sel    = rom_sel_q;
  assign rom_pixel  = rom_pixel_q;
  assign anim_frame = frame_q;
  assign pix_color  = pix_color_q;
  assign pix_opaque = pix_opaque_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed testbench for sprite_anim_ctrl (FRAMES_PER_STEP=8, COORD_W=10).
module tb_sprite_anim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [1:0]  dir;
  logic        moving;
  logic [9:0]  sprite_x, sprite_y, hcount, vcount;
  logic [5:0]  rom_width, rom_height;
  logic [15:0] rom_color;
  logic [2:0]  rom_sel;
  logic [16:0] rom_pixel;
  logic        anim_frame;
  logic [15:0] pix_color;
  logic        pix_opaque;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          op;      // 0 none, 1 set sprite_x + frame_tick, 2 set sprite_x only
    int          sx;
    int          w;
    int          hgt;
    int          h;
    int          v;
    logic [15:0] col;
    int          idx;
    logic        op_exp;
    logic [15:0] col_exp;
  } vec_t;

  sprite_anim_ctrl #(
    .FRAMES_PER_STEP(8),
    .TRANSPARENT    (16'hFFFF),
    .COORD_W        (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .dir       (dir),
    .moving    (moving),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .hcount    (hcount),
    .vcount    (vcount),
    .rom_width (rom_width),
    .rom_height(rom_height),
    .rom_color (rom_color),
    .rom_sel   (rom_sel),
    .rom_pixel (rom_pixel),
    .anim_frame(anim_frame),
    .pix_color (pix_color),
    .pix_opaque(pix_opaque)
  );

  always #5 clk = ~clk;

  // Pulse frame_tick for one clock, launched from a negedge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic commit_pos(input int x, input int y);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; moving = 1'b1; dir = 2'd1; frame_tick = 1'b0;
    sprite_x = 10'd7; sprite_y = 10'd9; hcount = 10'd8; vcount = 10'd10;
    rom_width = 6'd29; rom_height = 6'd33; rom_color = 16'h1234;
    repeat (2) @(negedge clk);
    total++; if (rom_sel !== 3'd0) begin bad++; $display("FAIL reset_rom_sel got=%0d want=0", rom_sel); end
    total++; if (rom_pixel !== 17'd0) begin bad++; $display("FAIL reset_rom_pixel got=%0d want=0", rom_pixel); end
    total++; if (anim_frame !== 1'b0) begin bad++; $display("FAIL reset_anim_frame got=%0b want=0", anim_frame); end
    total++; if (pix_color !== 16'd0) begin bad++; $display("FAIL reset_pix_color got=%h want=0000", pix_color); end
    total++; if (pix_opaque !== 1'b0) begin bad++; $display("FAIL reset_pix_opaque got=%0b want=0", pix_opaque); end
    rst_n = 1'b1;
    dir   = 2'd2;
    repeat (3) @(negedge clk);
    total++; if (rom_sel !== 3'd0) begin bad++; $display("FAIL pre_tick_rom_sel got=%b want=000", rom_sel); end
    total++; if (anim_frame !== 1'b0) begin bad++; $display("FAIL walk_a_frame got=%0b want=0", anim_frame); end
    $display("reset: rom_sel=%b anim_frame=%0b", rom_sel, anim_frame);
  endtask

  task automatic test_walk();
    logic [2:0] exp_sel;
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (anim_frame !== (i > 8)) begin
        bad++; $display("FAIL walk_frame tick=%0d got=%0b want=%0b", i, anim_frame, (i > 8));
      end
      tick();
      exp_sel = (i < 8) ? 3'b100 : ((i < 16) ? 3'b101 : 3'b100);
      total++;
      if (rom_sel !== exp_sel) begin
        bad++; $display("FAIL walk_rom_sel tick=%0d got=%b want=%b", i, rom_sel, exp_sel);
      end
      $display("walk tick %0d: anim_frame=%0b rom_sel=%b", i, anim_frame, rom_sel);
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    // Starts in WALK_A with counter 0; a dir change at tick 4 keeps the phase.
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) dir = 2'd1;
      tick();
      if (i == 4) begin
        total++; if (rom_sel !== 3'b010) begin bad++; $display("FAIL dir_change_sel got=%b want=010", rom_sel); end
      end
    end
    total++; if (rom_sel !== 3'b011) begin bad++; $display("FAIL walk_b_sel got=%b want=011", rom_sel); end
    total++; if (anim_frame !== 1'b1) begin bad++; $display("FAIL walk_b_frame got=%0b want=1", anim_frame); end
    dir = 2'd3; moving = 1'b0;
    tick();
    total++; if (anim_frame !== 1'b0) begin bad++; $display("FAIL stop_frame got=%0b want=0", anim_frame); end
    total++; if (rom_sel !== 3'b110) begin bad++; $display("FAIL stop_sel got=%b want=110", rom_sel); end
    $display("stop: anim_frame=%0b rom_sel=%b", anim_frame, rom_sel);
  endtask

  task automatic test_pixel();
    vec_t tbl [8];
    tbl = '{
      '{0, 100, 29, 33, 103, 52, 16'h2082,  61, 1'b1, 16'h2082},
      '{0, 100, 29, 33, 128, 52, 16'h2082,  86, 1'b1, 16'h2082},
      '{0, 100, 29, 33, 129, 52, 16'h2082,   0, 1'b0, 16'h0000},
      '{0, 100, 29, 33, 103, 83, 16'h2082,   0, 1'b0, 16'h0000},
      '{0, 100, 29, 33, 103, 52, 16'hFFFF,  61, 1'b0, 16'h0000},
      '{0, 100, 29, 33, 100, 50, 16'h07E0,   0, 1'b1, 16'h07E0},
      '{0, 100, 29, 33, 128, 82, 16'hF800, 956, 1'b1, 16'hF800},
      '{0, 100, 29, 33,  99, 52, 16'h2082,   0, 1'b0, 16'h0000}
    };
    commit_pos(100, 50);
    for (int i = 0; i < 8; i++) begin
      rom_width = 6'(tbl[i].w); rom_height = 6'(tbl[i].hgt);
      hcount = 10'(tbl[i].h); vcount = 10'(tbl[i].v); rom_color = tbl[i].col;
      @(negedge clk);
      total++;
      if (rom_pixel !== 17'(tbl[i].idx)) begin
        bad++; $display("FAIL pixel_idx vec=%0d got=%0d want=%0d", i, rom_pixel, tbl[i].idx);
      end
      @(negedge clk);
      total++;
      if (pix_opaque !== tbl[i].op_exp || pix_color !== tbl[i].col_exp) begin
        bad++; $display("FAIL pixel_out vec=%0d got=%0b/%h want=%0b/%h", i, pix_opaque, pix_color, tbl[i].op_exp, tbl[i].col_exp);
      end
      $display("pixel h=%0d v=%0d: idx=%0d opaque=%0b color=%h", tbl[i].h, tbl[i].v, rom_pixel, pix_opaque, pix_color);
    end
  endtask

  task automatic test_edge();
    vec_t tbl [8];
    tbl = '{
      '{1, 1010, 29, 33, 1023, 60, 16'h2082, 303, 1'b1, 16'h2082},
      '{0, 1010, 29, 33,    5, 60, 16'h2082,   0, 1'b0, 16'h0000},
      '{2,    0, 29, 33,    5, 60, 16'h2082,   0, 1'b0, 16'h0000},
      '{0,    0, 29, 33, 1023, 60, 16'h2082, 303, 1'b1, 16'h2082},
      '{1,    0, 29, 33,    5, 60, 16'h2082, 295, 1'b1, 16'h2082},
      '{0,    0,  0, 33,    5, 60, 16'h2082,   0, 1'b0, 16'h0000},
      '{0,    0, 29,  0,    5, 60, 16'h2082,   0, 1'b0, 16'h0000},
      '{0,    0, 29, 33,   28, 82, 16'h2082, 956, 1'b1, 16'h2082}
    };
    sprite_y = 10'd50;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].op == 1) commit_pos(tbl[i].sx, 50);
      else if (tbl[i].op == 2) sprite_x = 10'(tbl[i].sx);
      rom_width = 6'(tbl[i].w); rom_height = 6'(tbl[i].hgt);
      hcount = 10'(tbl[i].h); vcount = 10'(tbl[i].v); rom_color = tbl[i].col;
      @(negedge clk);
      total++;
      if (rom_pixel !== 17'(tbl[i].idx)) begin
        bad++; $display("FAIL edge_idx vec=%0d got=%0d want=%0d", i, rom_pixel, tbl[i].idx);
      end
      @(negedge clk);
      total++;
      if (pix_opaque !== tbl[i].op_exp || pix_color !== tbl[i].col_exp) begin
        bad++; $display("FAIL edge_out vec=%0d got=%0b/%h want=%0b/%h", i, pix_opaque, pix_color, tbl[i].op_exp, tbl[i].col_exp);
      end
      $display("edge h=%0d v=%0d: idx=%0d opaque=%0b color=%h", tbl[i].h, tbl[i].v, rom_pixel, pix_opaque, pix_color);
    end
  endtask

  task automatic test_back_to_back();
    int exp_idx;
    logic exp_op;
    commit_pos(100, 50);
    rom_width = 6'd29; rom_height = 6'd33; rom_color = 16'h2082; vcount = 10'd52;
    // One new pixel per clock: x = 100..104 in the box, then 129 outside.
    for (int i = 0; i < 8; i++) begin
      if (i >= 1) begin
        exp_idx = (i - 1 <= 4) ? 58 + (i - 1) : 0;
        total++;
        if (rom_pixel !== 17'(exp_idx)) begin
          bad++; $display("FAIL b2b_idx step=%0d got=%0d want=%0d", i, rom_pixel, exp_idx);
        end
      end
      if (i >= 2) begin
        exp_op = (i - 2 <= 4);
        total++;
        if (pix_opaque !== exp_op) begin
          bad++; $display("FAIL b2b_opaque step=%0d got=%0b want=%0b", i, pix_opaque, exp_op);
        end
      end
      hcount = (i <= 4) ? 10'(100 + i) : 10'd129;
      $display("b2b step %0d: idx=%0d opaque=%0b", i, rom_pixel, pix_opaque);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midline();
    // Positions clear to 0 under reset, so (5,5) lands in a 29x33 box at 150.
    rom_width = 6'd29; rom_height = 6'd33; rom_color = 16'h2082;
    hcount = 10'd103; vcount = 10'd52;
    repeat (2) @(negedge clk);
    total++; if (pix_opaque !== 1'b1) begin bad++; $display("FAIL pre_reset_opaque got=%0b want=1", pix_opaque); end
    hcount = 10'd5; vcount = 10'd5;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pix_opaque !== 1'b0) begin bad++; $display("FAIL async_reset_opaque got=%0b want=0", pix_opaque); end
    total++; if (rom_pixel !== 17'd0) begin bad++; $display("FAIL async_reset_idx got=%0d want=0", rom_pixel); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (pix_opaque !== 1'b0) begin bad++; $display("FAIL flush_opaque got=%0b want=0", pix_opaque); end
    total++; if (rom_pixel !== 17'd150) begin bad++; $display("FAIL flush_idx got=%0d want=150", rom_pixel); end
    @(negedge clk);
    total++; if (pix_opaque !== 1'b1 || pix_color !== 16'h2082) begin
      bad++; $display("FAIL refill_out got=%0b/%h want=1/2082", pix_opaque, pix_color);
    end
    $display("reset midline: idx=%0d opaque=%0b color=%h", rom_pixel, pix_opaque, pix_color);
  endtask

  initial begin
    test_reset();
    test_walk();
    test_stop();
    test_pixel();
    test_edge();
    test_back_to_back();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
